// File: rtl/bypass_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bypass_ctrl                                                   |
// | Purpose  : ID-stage operand bypass network, load-use interlock and a     |
// |            single-entry scoreboard for one outstanding long-latency op.  |
// | Ports    : clk, resetn (sync, active-low)                                |
// |            re1/re2, r1addr/r2addr, r1data/r2data, imme  - ID operands    |
// |            fwd_wreg/fwd_wraddr/fwd_ready/fwd_wrdata     - NSRC sources   |
// |                                                 (index 0 = youngest)     |
// |            long_issue/long_wraddr/long_lat/long_done    - long unit      |
// |            opr1/opr2 (resolved operands), stall_req, busy                |
// |            ld_stall_cnt/lg_stall_cnt (only with BYPASS_STALLCNT_EN)      |
// | Config   : `define BYPASS_STALLCNT_EN adds saturating stall counters.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module bypass_ctrl #(
  parameter int NSRC = 2,
  parameter int DW   = 32,
  parameter int LATW = 6
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 re1,
  input  logic                 re2,
  input  logic [4:0]           r1addr,
  input  logic [4:0]           r2addr,
  input  logic [DW-1:0]        r1data,
  input  logic [DW-1:0]        r2data,
  input  logic [DW-1:0]        imme,
  input  logic [NSRC-1:0]      fwd_wreg,
  input  logic [5*NSRC-1:0]    fwd_wraddr,
  input  logic [NSRC-1:0]      fwd_ready,
  input  logic [DW*NSRC-1:0]   fwd_wrdata,
  input  logic                 long_issue,
  input  logic [4:0]           long_wraddr,
  input  logic [LATW-1:0]      long_lat,
  input  logic                 long_done,
`ifdef BYPASS_STALLCNT_EN
  output logic [31:0]          ld_stall_cnt,
  output logic [31:0]          lg_stall_cnt,
`endif
  output logic [DW-1:0]        opr1,
  output logic [DW-1:0]        opr2,
  output logic                 stall_req,
  output logic                 busy
);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_LDSTALL = 2'd1;
  localparam logic [1:0] ST_LGSTALL = 2'd2;

  // Returns {load_use_stall, operand}. The loop runs oldest to youngest so
  // the youngest matching source overwrites, and only its ready bit counts.
  function automatic logic [DW:0] resolve_opr(
    input logic                re,
    input logic [4:0]          addr,
    input logic [DW-1:0]       rf,
    input logic [DW-1:0]       imm,
    input logic [NSRC-1:0]     wreg,
    input logic [5*NSRC-1:0]   wa,
    input logic [NSRC-1:0]     rdy,
    input logic [DW*NSRC-1:0]  wd
  );
    logic [DW-1:0] d;
    logic          lu;
    d  = rf;
    lu = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (wreg[i] && (wa[5*i +: 5] == addr)) begin
        d  = wd[DW*i +: DW];
        lu = ~rdy[i];
      end
    end
    if (!re) begin
      d  = imm;
      lu = 1'b0;
    end else if (addr == 5'd0) begin
      // r0 is hard-wired zero: never forwarded, never interlocked
      d  = '0;
      lu = 1'b0;
    end
    return {lu, d};
  endfunction

  logic [DW:0]     res1, res2;
  logic            ld_haz;
  logic            lg_haz;

  logic            busy_q,    busy_d;
  logic [4:0]      sb_addr_q, sb_addr_d;
  logic [LATW-1:0] sb_cnt_q,  sb_cnt_d;
  logic [1:0]      state_q,   state_d;

  // ---------------- operand resolution and hazards ----------------
  always_comb begin
    res1 = resolve_opr(re1, r1addr, r1data, imme, fwd_wreg, fwd_wraddr,
                       fwd_ready, fwd_wrdata);
    res2 = resolve_opr(re2, r2addr, r2data, imme, fwd_wreg, fwd_wraddr,
                       fwd_ready, fwd_wrdata);
    opr1   = res1[DW-1:0];
    opr2   = res2[DW-1:0];
    ld_haz = res1[DW] | res2[DW];
    // Long hazard also covers the structural case: a second long op cannot
    // be accepted while the single scoreboard entry is occupied.
    lg_haz = (busy_q && re1 && (r1addr == sb_addr_q) && (r1addr != 5'd0)) ||
             (busy_q && re2 && (r2addr == sb_addr_q) && (r2addr != 5'd0)) ||
             (busy_q && long_issue);
    stall_req = ld_haz | lg_haz;
    busy      = busy_q;
  end

  // ---------------- scoreboard ----------------
  always_comb begin
    busy_d    = busy_q;
    sb_addr_d = sb_addr_q;
    sb_cnt_d  = sb_cnt_q;
    if (busy_q) begin
      // Issues while busy are dropped here; the issuer sees stall_req.
      sb_cnt_d = sb_cnt_q - LATW'(1);
      if (long_done || (sb_cnt_q == LATW'(1))) begin
        busy_d   = 1'b0;
        sb_cnt_d = '0;
      end
    end else if (long_issue) begin
      busy_d    = 1'b1;
      sb_addr_d = long_wraddr;
      sb_cnt_d  = (long_lat == '0) ? LATW'(1) : long_lat;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      busy_q    <= 1'b0;
      sb_addr_q <= 5'd0;
      sb_cnt_q  <= '0;
    end else begin
      busy_q    <= busy_d;
      sb_addr_q <= sb_addr_d;
      sb_cnt_q  <= sb_cnt_d;
    end
  end

  // ---------------- stall-classification FSM ----------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (ld_haz)      state_d = ST_LDSTALL;
        else if (lg_haz) state_d = ST_LGSTALL;
      end
      ST_LDSTALL: if (!ld_haz) state_d = ST_RUN;
      ST_LGSTALL: if (!lg_haz) state_d = ST_RUN;
      default:    state_d = ST_RUN;
    endcase
  end

`ifdef BYPASS_STALLCNT_EN
  // FSM output decode; the counters are its only consumers.
  logic        in_ld, in_lg;
  logic [31:0] ld_cnt_q, ld_cnt_d;
  logic [31:0] lg_cnt_q, lg_cnt_d;

  always_comb begin
    in_ld = (state_q == ST_LDSTALL);
    in_lg = (state_q == ST_LGSTALL);
  end

  always_comb begin
    ld_cnt_d = ld_cnt_q;
    lg_cnt_d = lg_cnt_q;
    if (in_ld && (ld_cnt_q != '1)) ld_cnt_d = ld_cnt_q + 32'd1;
    if (in_lg && (lg_cnt_q != '1)) lg_cnt_d = lg_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ld_cnt_q <= '0;
      lg_cnt_q <= '0;
    end else begin
      ld_cnt_q <= ld_cnt_d;
      lg_cnt_q <= lg_cnt_d;
    end
  end

  assign ld_stall_cnt = ld_cnt_q;
  assign lg_stall_cnt = lg_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bypass_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_bypass_ctrl                                                |
// | Purpose  : Directed self-checking bench for bypass_ctrl (NSRC=2, DW=32). |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_bypass_ctrl;
  localparam int NSRC = 2;
  localparam int DW   = 32;
  localparam int LATW = 6;

  logic              clk = 1'b0;
  logic              resetn;
  logic              re1, re2;
  logic [4:0]        r1addr, r2addr;
  logic [DW-1:0]     r1data, r2data, imme;
  logic [NSRC-1:0]   fwd_wreg, fwd_ready;
  logic [5*NSRC-1:0] fwd_wraddr;
  logic [DW*NSRC-1:0] fwd_wrdata;
  logic              long_issue, long_done;
  logic [4:0]        long_wraddr;
  logic [LATW-1:0]   long_lat;
  logic [DW-1:0]     opr1, opr2;
  logic              stall_req, busy;
`ifdef BYPASS_STALLCNT_EN
  logic [31:0]       ld_stall_cnt, lg_stall_cnt;
`endif

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  bypass_ctrl #(.NSRC(NSRC), .DW(DW), .LATW(LATW)) dut (
    .clk(clk), .resetn(resetn),
    .re1(re1), .re2(re2), .r1addr(r1addr), .r2addr(r2addr),
    .r1data(r1data), .r2data(r2data), .imme(imme),
    .fwd_wreg(fwd_wreg), .fwd_wraddr(fwd_wraddr), .fwd_ready(fwd_ready),
    .fwd_wrdata(fwd_wrdata),
    .long_issue(long_issue), .long_wraddr(long_wraddr), .long_lat(long_lat),
    .long_done(long_done),
`ifdef BYPASS_STALLCNT_EN
    .ld_stall_cnt(ld_stall_cnt), .lg_stall_cnt(lg_stall_cnt),
`endif
    .opr1(opr1), .opr2(opr2), .stall_req(stall_req), .busy(busy)
  );

  // Advance one clock; inputs are then changed 1ns after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    re1 = 0; re2 = 0; r1addr = 0; r2addr = 0;
    r1data = 0; r2data = 0; imme = 0;
    fwd_wreg = 0; fwd_ready = '1; fwd_wraddr = 0; fwd_wrdata = 0;
    long_issue = 0; long_done = 0; long_wraddr = 0; long_lat = 0;
  endtask

  task automatic test_reset;
    idle_inputs();
    resetn = 0;
    long_issue = 1; long_wraddr = 5'd3; long_lat = 6'd5;  // ignored in reset
    tick(); tick();
    long_issue = 0;
    resetn = 1;
    re1 = 0; imme = 32'h0000_ABCD;
    re2 = 1; r2addr = 5'd4; r2data = 32'h0000_1234;
    #1;
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (stall_req !== 1'b0) begin failed++; $display("FAIL reset_stall: got %b expected 0", stall_req); end
    tests++; if (opr1 !== 32'h0000_ABCD) begin failed++; $display("FAIL reset_imme: got %h expected 0000abcd", opr1); end
    tests++; if (opr2 !== 32'h0000_1234) begin failed++; $display("FAIL reset_rf: got %h expected 00001234", opr2); end
    tick();
  endtask

  task automatic test_fwd_priority;
    idle_inputs();
    fwd_wreg = 2'b11; fwd_wraddr = {5'd5, 5'd5};
    fwd_wrdata = {32'h22, 32'h11}; fwd_ready = 2'b11;
    re1 = 1; r1addr = 5'd5; r1data = 32'hDEAD;
    #1;
    tests++; if (opr1 !== 32'h11) begin failed++; $display("FAIL fwd_youngest: got %h expected 00000011", opr1); end
    tests++; if (stall_req !== 1'b0) begin failed++; $display("FAIL fwd_nostall: got %b expected 0", stall_req); end
    fwd_wreg = 2'b10;
    re2 = 1; r2addr = 5'd5;
    #1;
    tests++; if (opr2 !== 32'h22) begin failed++; $display("FAIL fwd_older: got %h expected 00000022", opr2); end
    tick();
  endtask

  task automatic test_r0;
    idle_inputs();
    fwd_wreg = 2'b01; fwd_wraddr = {5'd0, 5'd0}; fwd_wrdata = {32'h0, 32'hFFFF};
    fwd_ready = 2'b00;  // an unready r0 write must not interlock either
    re1 = 1; r1addr = 5'd0; r1data = 32'h77;
    #1;
    tests++; if (opr1 !== 32'h0) begin failed++; $display("FAIL r0_zero: got %h expected 00000000", opr1); end
    tests++; if (stall_req !== 1'b0) begin failed++; $display("FAIL r0_nostall: got %b expected 0", stall_req); end
    tick();
  endtask

  task automatic test_load_use;
    idle_inputs();
    fwd_wreg = 2'b11; fwd_wraddr = {5'd7, 5'd7};
    fwd_wrdata = {32'h66, 32'h0}; fwd_ready = 2'b10;
    re2 = 1; r2addr = 5'd7;
    #1;
    tests++; if (stall_req !== 1'b1) begin failed++; $display("FAIL ldu_stall: got %b expected 1", stall_req); end
    tick();
    fwd_ready = 2'b11; fwd_wrdata = {32'h66, 32'h55};
    #1;
    tests++; if (opr2 !== 32'h55) begin failed++; $display("FAIL ldu_data: got %h expected 00000055", opr2); end
    tests++; if (stall_req !== 1'b0) begin failed++; $display("FAIL ldu_release: got %b expected 0", stall_req); end
    tick();
    idle_inputs();
    #1;
`ifdef BYPASS_STALLCNT_EN
    tests++; if (ld_stall_cnt !== 32'd1) begin failed++; $display("FAIL ld_cnt: got %0d expected 1", ld_stall_cnt); end
    tests++; if (lg_stall_cnt !== 32'd0) begin failed++; $display("FAIL lg_cnt: got %0d expected 0", lg_stall_cnt); end
`endif
    tick();
  endtask

  task automatic test_long;
    idle_inputs();
    long_issue = 1; long_wraddr = 5'd9; long_lat = 6'd3;
    #1;
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL long_pre_busy: got %b expected 0", busy); end
    tick();
    long_issue = 0; re1 = 1; r1addr = 5'd9;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests++; if (stall_req !== 1'b1) begin failed++; $display("FAIL long_stall[%0d]: got %b expected 1", c, stall_req); end
      tests++; if (busy !== 1'b1) begin failed++; $display("FAIL long_busy[%0d]: got %b expected 1", c, busy); end
      tick();
    end
    #1;
    tests++; if (stall_req !== 1'b0) begin failed++; $display("FAIL long_release: got %b expected 0", stall_req); end
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL long_idle: got %b expected 0", busy); end
    // zero latency behaves as one cycle
    re1 = 0; long_issue = 1; long_wraddr = 5'd10; long_lat = 6'd0;
    tick();
    long_issue = 0;
    #1;
    tests++; if (busy !== 1'b1) begin failed++; $display("FAIL lat0_busy: got %b expected 1", busy); end
    tick();
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL lat0_done: got %b expected 0", busy); end
    tick();
  endtask

  task automatic test_back_to_back;
    idle_inputs();
    long_issue = 1; long_wraddr = 5'd9; long_lat = 6'd10;
    tick();
    long_wraddr = 5'd12; long_lat = 6'd2;  // second issue while busy
    #1;
    tests++; if (stall_req !== 1'b1) begin failed++; $display("FAIL struct_stall: got %b expected 1", stall_req); end
    tick();
    long_issue = 0;
    re1 = 1; r1addr = 5'd9;
    fwd_wreg = 2'b01; fwd_wraddr = {5'd0, 5'd9}; fwd_wrdata = {32'h0, 32'h99};
    #1;
    tests++; if (stall_req !== 1'b1) begin failed++; $display("FAIL sb_addr_kept: got %b expected 1", stall_req); end
    tests++; if (opr1 !== 32'h99) begin failed++; $display("FAIL busy_fwd: got %h expected 00000099", opr1); end
    re1 = 0; fwd_wreg = 2'b00; re2 = 1; r2addr = 5'd12;
    #1;
    tests++; if (stall_req !== 1'b0) begin failed++; $display("FAIL dropped_issue: got %b expected 0", stall_req); end
    tick();
    re2 = 0;
    #1;
    tests++; if (busy !== 1'b1) begin failed++; $display("FAIL still_busy: got %b expected 1", busy); end
    long_done = 1; long_issue = 1; long_wraddr = 5'd13; long_lat = 6'd4;
    tick();
    long_done = 0; long_issue = 0;
    re1 = 1; r1addr = 5'd9;
    #1;
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL done_clear: got %b expected 0", busy); end
    tests++; if (stall_req !== 1'b0) begin failed++; $display("FAIL done_nostall: got %b expected 0", stall_req); end
    tick();
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL done_wins: got %b expected 0", busy); end
    tick();
  endtask

  task automatic test_reset_mid;
    idle_inputs();
    long_issue = 1; long_wraddr = 5'd20; long_lat = 6'd20;
    tick();
    long_issue = 0;
    #1;
    tests++; if (busy !== 1'b1) begin failed++; $display("FAIL mid_busy: got %b expected 1", busy); end
    resetn = 0;
    tick();
    resetn = 1;
    re1 = 1; r1addr = 5'd20;
    #1;
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL mid_reset_busy: got %b expected 0", busy); end
    tests++; if (stall_req !== 1'b0) begin failed++; $display("FAIL mid_reset_stall: got %b expected 0", stall_req); end
    tick();
  endtask

  initial begin
    test_reset();
    test_fwd_priority();
    test_r0();
    test_load_use();
    test_long();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
